// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT frame to UART byte serializer: FSM encoding,
// default sync header, byte-index width and frame length helper.
package fft_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         IDX_W         = 7;

    // Bytes on the wire for one frame: two per word plus optional header and checksum.
    function automatic int n_bytes(input int fft_size, input int hdr_en);
        return 2 * fft_size + ((hdr_en != 0) ? 2 : 0);
    endfunction

endpackage

// File: rtl/tx_watchdog_timer.sv
// Counts consecutive enabled cycles since the last clear and pulses expired_o
// on the TIMEOUT_CYCLES-th one.
module tx_watchdog_timer #(
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_uart_serializer.sv
// Snapshots one FFT frame on i_frame_valid and streams it byte-wise to a UART
// transmitter over a start/done handshake, with optional sync header and checksum.
module fft_frame_uart_serializer
    import fft_uart_pkg::*;
#(
    parameter int         FFT_SIZE       = 32,
    parameter int         WORD_SIZE      = 16,
    parameter int         DATA_LENGTH    = 8,
    parameter int         HDR_EN         = 1,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 8192
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_frame_valid,
    input  logic [FFT_SIZE*WORD_SIZE-1:0]   i_frame,
    output logic                            o_frame_ready,
    output logic                            o_tx_start,
    output logic [DATA_LENGTH-1:0]          o_tx_byte,
    input  logic                            i_tx_done,
    output logic [IDX_W-1:0]                o_byte_idx,
    output logic                            o_frame_sent,
    output logic                            o_timeout,
    output logic [7:0]                      o_drop_cnt
);

    localparam int               N_BYTES  = n_bytes(FFT_SIZE, HDR_EN);
    localparam int               N_DATA   = 2 * FFT_SIZE;
    localparam int               HOFF     = (HDR_EN != 0) ? 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    if (FFT_SIZE > 63) begin : g_err_fft_size
        $error("fft_frame_uart_serializer: FFT_SIZE must not exceed 63");
    end
    if (WORD_SIZE != 16) begin : g_err_word_size
        $error("fft_frame_uart_serializer: WORD_SIZE must be 16");
    end
    if (DATA_LENGTH != 8) begin : g_err_data_length
        $error("fft_frame_uart_serializer: DATA_LENGTH must be 8");
    end

    state_e                          state_q, state_d;
    logic [FFT_SIZE*WORD_SIZE-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [7:0]                      chk_q, chk_d;
    logic [7:0]                      byte_q, byte_d;
    logic [7:0]                      drop_q, drop_d;
    logic                            wd_clear, wd_en, wd_expired;
    logic                            is_data;

    // Byte idx of the wire sequence; data byte d is simply bits [8d +: 8] because
    // each word is sent low byte first.
    function automatic logic [7:0] pick(input logic [FFT_SIZE*WORD_SIZE-1:0] fr,
                                        input logic [IDX_W-1:0] idx,
                                        input logic [7:0] chk);
        int d;
        d = int'(idx) - HOFF;
        if (HOFF == 1 && idx == '0)       return SYNC_BYTE;
        if (HOFF == 1 && idx == LAST_IDX) return chk;
        return fr[d*8 +: 8];
    endfunction

    assign is_data = (int'(idx_q) >= HOFF) && (int'(idx_q) < HOFF + N_DATA);

    tx_watchdog_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        byte_d        = byte_q;
        drop_d        = drop_q;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;
        o_frame_ready = 1'b0;
        o_tx_start    = 1'b0;
        o_frame_sent  = 1'b0;
        o_timeout     = 1'b0;

        // Capture only happens in IDLE, so any other state turns a frame into a drop.
        if (i_frame_valid && state_q != ST_IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                o_frame_ready = 1'b1;
                if (i_frame_valid) begin
                    shadow_d = i_frame;
                    idx_d    = '0;
                    chk_d    = 8'h00;
                    byte_d   = pick(i_frame, '0, 8'h00);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_tx_start = 1'b1;
                wd_clear   = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                if (i_tx_done) begin
                    if (is_data) begin
                        chk_d = chk_q + byte_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        // Next byte is loaded here so it is valid on the coming start pulse.
                        idx_d   = idx_q + IDX_W'(1);
                        byte_d  = pick(shadow_q, idx_q + IDX_W'(1), chk_d);
                        state_d = ST_ISSUE;
                    end
                end else if (wd_expired) begin
                    o_timeout = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: begin
                o_frame_sent = 1'b1;
                idx_d        = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            chk_q    <= 8'h00;
            byte_q   <= 8'h00;
            drop_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            byte_q   <= byte_d;
            drop_q   <= drop_d;
        end
    end

    assign o_tx_byte  = byte_q;
    assign o_byte_idx = idx_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_fft_frame_uart_serializer.sv
// Directed/randomized bench: a header-framed and a headerless serializer run side by
// side against a queue-based byte-stream model and a UART done-pulse responder.
module tb_fft_frame_uart_serializer;

    localparam int FS = 32;
    localparam int WS = 16;
    localparam int T  = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              fv    = 1'b0;
    logic              spur  = 1'b0;
    logic [FS*WS-1:0]  fr    = '0;

    logic       rdy_h, st_h, sent_h, to_h, resp_h, done_h;
    logic       rdy_n, st_n, sent_n, to_n, resp_n, done_n;
    logic [7:0] byte_h, drop_h, byte_n, drop_n;
    logic [6:0] idx_h, idx_n;

    assign done_h = resp_h | spur;
    assign done_n = resp_n | spur;

    fft_frame_uart_serializer #(.FFT_SIZE(FS), .WORD_SIZE(WS), .DATA_LENGTH(8), .HDR_EN(1),
                                .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(fv), .i_frame(fr),
        .o_frame_ready(rdy_h), .o_tx_start(st_h), .o_tx_byte(byte_h), .i_tx_done(done_h),
        .o_byte_idx(idx_h), .o_frame_sent(sent_h), .o_timeout(to_h), .o_drop_cnt(drop_h));

    fft_frame_uart_serializer #(.FFT_SIZE(FS), .WORD_SIZE(WS), .DATA_LENGTH(8), .HDR_EN(0),
                                .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(fv), .i_frame(fr),
        .o_frame_ready(rdy_n), .o_tx_start(st_n), .o_tx_byte(byte_n), .i_tx_done(done_n),
        .o_byte_idx(idx_n), .o_frame_sent(sent_n), .o_timeout(to_n), .o_drop_cnt(drop_n));

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int dly    = 20;
    int hold_h = -1;
    int hold_n = -1;
    int exp_drop = 0;
    int nsent_h = 0, nsent_n = 0, nto_h = 0, unst_h = 0, unst_n = 0;
    int k_h, k_n;
    logic [7:0] b_h, b_n;
    logic [7:0] got_h[$], got_n[$], exp_q[$];
    int         gi_h[$], gi_n[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sent_h) nsent_h <= nsent_h + 1;
        if (sent_n) nsent_n <= nsent_n + 1;
        if (to_h)   nto_h   <= nto_h + 1;
    end

    // UART stand-ins: log every started byte, answer with done dly clocks later.
    initial begin
        resp_h = 1'b0;
        forever begin
            @(negedge clk);
            if (st_h) begin
                b_h = byte_h; k_h = got_h.size();
                got_h.push_back(b_h); gi_h.push_back(int'(idx_h));
                if (k_h != hold_h) begin
                    repeat (dly) @(posedge clk);
                    #1;
                    if (!rdy_h && byte_h !== b_h) unst_h++;
                    resp_h = 1'b1;
                    @(posedge clk); #1 resp_h = 1'b0;
                end
            end
        end
    end

    initial begin
        resp_n = 1'b0;
        forever begin
            @(negedge clk);
            if (st_n) begin
                b_n = byte_n; k_n = got_n.size();
                got_n.push_back(b_n); gi_n.push_back(int'(idx_n));
                if (k_n != hold_n) begin
                    repeat (dly) @(posedge clk);
                    #1;
                    if (!rdy_n && byte_n !== b_n) unst_n++;
                    resp_n = 1'b1;
                    @(posedge clk); #1 resp_n = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: wire order is [A5] low/high byte of each word [sum of data bytes mod 256].
    task automatic build_exp(input logic [FS*WS-1:0] f, input bit hdr);
        int sum;
        logic [15:0] w;
        exp_q.delete();
        sum = 0;
        if (hdr) exp_q.push_back(8'hA5);
        for (int k = 0; k < FS; k++) begin
            w = f[k*WS +: WS];
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            sum = sum + int'(w[7:0]) + int'(w[15:8]);
        end
        if (hdr) exp_q.push_back(8'(sum % 256));
    endtask

    task automatic cmp_stream(input string tag, input logic [7:0] g[$], input int gi[$], input int base);
        chk($sformatf("%s nbytes", tag), 32'(g.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < g.size(); i++) begin
            chk($sformatf("%s byte%0d", tag, i), 32'(g[base+i]), 32'(exp_q[i]));
            chk($sformatf("%s idx%0d", tag, i), 32'(gi[base+i]), 32'(i));
        end
    endtask

    task automatic scramble_input();
        for (int k = 0; k < FS*WS/32; k++) fr[k*32 +: 32] = $urandom;
    endtask

    task automatic random_frame(output logic [FS*WS-1:0] f);
        for (int k = 0; k < FS*WS/32; k++) f[k*32 +: 32] = $urandom;
    endtask

    // One full frame on both DUTs; optional spurious done in ISSUE and a burst of
    // ndrop frame_valid pulses once byte drop_at is in flight.
    task automatic run_frame(input logic [FS*WS-1:0] f, input string tag, input bit spur_issue,
                             input int drop_at, input int ndrop);
        int bh, bn, sh, sn, t0;
        bit dropped;
        bh = got_h.size(); bn = got_n.size(); sh = nsent_h; sn = nsent_n;
        dropped = 1'b0;
        @(posedge clk); #1; fr = f; fv = 1'b1;
        @(posedge clk); #1; fv = 1'b0; scramble_input();
        chk({tag, " start latency h"}, 32'(st_h), 32'd1);
        chk({tag, " start latency n"}, 32'(st_n), 32'd1);
        chk({tag, " busy ready h"}, 32'(rdy_h), 32'd0);
        if (spur_issue) begin
            spur = 1'b1;
            @(posedge clk); #1 spur = 1'b0;
        end
        t0 = cyc;
        while ((nsent_h == sh || nsent_n == sn) && (cyc - t0) < 8000) begin
            @(posedge clk); #1;
            if (ndrop > 0 && !dropped && got_h.size() >= bh + drop_at + 1) begin
                dropped = 1'b1;
                scramble_input(); fv = 1'b1;
                repeat (ndrop) begin @(posedge clk); #1; end
                fv = 1'b0;
                exp_drop = (exp_drop + ndrop > 255) ? 255 : exp_drop + ndrop;
            end
        end
        chk({tag, " frame_sent h"}, 32'(nsent_h - sh), 32'd1);
        chk({tag, " frame_sent n"}, 32'(nsent_n - sn), 32'd1);
        chk({tag, " idle ready h"}, 32'(rdy_h), 32'd1);
        chk({tag, " drop_cnt h"}, 32'(drop_h), 32'(exp_drop));
        chk({tag, " drop_cnt n"}, 32'(drop_n), 32'(exp_drop));
        build_exp(f, 1'b1); cmp_stream({tag, " hdr"}, got_h, gi_h, bh);
        build_exp(f, 1'b0); cmp_stream({tag, " nohdr"}, got_n, gi_n, bn);
    endtask

    logic [FS*WS-1:0] f;
    int n, sh;

    initial begin
        // Reset values
        repeat (3) @(posedge clk); #1;
        chk("rst ready", 32'(rdy_h), 32'd1);
        chk("rst start", 32'(st_h), 32'd0);
        chk("rst byte", 32'(byte_h), 32'd0);
        chk("rst idx", 32'(idx_h), 32'd0);
        chk("rst sent", 32'(sent_h), 32'd0);
        chk("rst timeout", 32'(to_h), 32'd0);
        chk("rst drop", 32'(drop_h), 32'd0);
        rst_n = 1'b1;

        // Spurious done while idle
        repeat (2) @(posedge clk); #1;
        spur = 1'b1;
        repeat (5) @(posedge clk); #1;
        spur = 1'b0;
        chk("spur idle start", 32'(st_h), 32'd0);
        chk("spur idle ready", 32'(rdy_h), 32'd1);
        chk("spur idle idx", 32'(idx_n), 32'd0);

        // Counting pattern with 20-clock done latency
        dly = 20;
        for (int k = 0; k < FS; k++) f[k*WS +: WS] = 16'h0100 + 16'(k);
        run_frame(f, "ramp", 1'b0, 0, 0);

        // All-ones frame, spurious done during ISSUE
        f = '1;
        dly = 1 + int'($urandom_range(0, 4));
        run_frame(f, "ones", 1'b1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            random_frame(f);
            dly = 1 + int'($urandom_range(0, 7));
            run_frame(f, $sformatf("rand%0d", r), 1'b0, 0, 0);
        end

        // One drop while byte 10 is in flight
        random_frame(f);
        dly = 3;
        run_frame(f, "drop1", 1'b0, 10, 1);

        // Done withheld on byte 5 -> watchdog abort
        random_frame(f);
        dly = 3;
        hold_h = got_h.size() + 5; hold_n = got_n.size() + 5;
        sh = nsent_h;
        @(posedge clk); #1; fr = f; fv = 1'b1;
        @(posedge clk); #1; fv = 1'b0;
        n = 0;
        while (!(st_h && idx_h == 7'd5) && n < 2000) begin @(negedge clk); n++; end
        chk("wd reached byte5", 32'(idx_h), 32'd5);
        n = 0;
        while (!to_h && n < T + 50) begin @(negedge clk); n++; end
        chk("wd latency", 32'(n), 32'(T));
        chk("wd timeout n", 32'(to_n), 32'd1);
        @(negedge clk);
        chk("wd pulse width", 32'(to_h), 32'd0);
        chk("wd ready", 32'(rdy_h), 32'd1);
        chk("wd idx", 32'(idx_h), 32'd0);
        repeat (10) @(negedge clk);
        chk("wd no frame_sent", 32'(nsent_h - sh), 32'd0);
        chk("wd one pulse", 32'(nto_h), 32'd1);
        hold_h = -1; hold_n = -1;

        // Async reset while waiting on byte 30
        random_frame(f);
        dly = 20;
        @(posedge clk); #1; fr = f; fv = 1'b1;
        @(posedge clk); #1; fv = 1'b0;
        n = 0;
        while (!(st_h && idx_h == 7'd30) && n < 2000) begin @(negedge clk); n++; end
        chk("rstmid reached byte30", 32'(idx_h), 32'd30);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid ready", 32'(rdy_h), 32'd1);
        chk("rstmid start", 32'(st_h), 32'd0);
        chk("rstmid byte", 32'(byte_h), 32'd0);
        chk("rstmid idx", 32'(idx_h), 32'd0);
        chk("rstmid drop", 32'(drop_h), 32'd0);
        chk("rstmid ready n", 32'(rdy_n), 32'd1);
        exp_drop = 0;
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        random_frame(f);
        dly = 2;
        run_frame(f, "after rst", 1'b0, 0, 0);

        // 300 back-to-back drops saturate the counter
        random_frame(f);
        dly = 20;
        run_frame(f, "drop300", 1'b0, 10, 300);
        chk("drop sat value", 32'(drop_h), 32'd255);

        chk("byte stable h", 32'(unst_h), 32'd0);
        chk("byte stable n", 32'(unst_n), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
